// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-client arbiter that shares one word-granular memory port between the
// instruction cache (client 0) and the data cache (client 1). A client that
// wants the port while the arbiter is idle is granted in the same cycle, with no
// added latency. It then keeps ownership while its hold input is high or while
// any of its reads are still outstanding. Read data goes to both clients, and
// only the owner sees valid.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cN_ren / i_cN_wen          client N read / write request (N = 0, 1)
//   i_cN_addr / i_cN_wdata       client N word address / write data
//   i_cN_hold                    client N keep-ownership (line fill in progress)
//   o_cN_ready                   client N request is accepted this cycle
//   o_cN_rdata / o_cN_valid      read data (broadcast) / valid for client N
//   i_mem_ready                  memory can accept a request
//   o_mem_addr/ren/wen/wdata     request forwarded to memory
//   i_mem_rdata / i_mem_valid    memory read response
//   o_owner                      debug: 00 none, 01 client 0, 10 client 1
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_c0_ren,
   input  logic        i_c0_wen,
   input  logic [31:0] i_c0_addr,
   input  logic [31:0] i_c0_wdata,
   input  logic        i_c0_hold,
   output logic        o_c0_ready,
   output logic [31:0] o_c0_rdata,
   output logic        o_c0_valid,
   input  logic        i_c1_ren,
   input  logic        i_c1_wen,
   input  logic [31:0] i_c1_addr,
   input  logic [31:0] i_c1_wdata,
   input  logic        i_c1_hold,
   output logic        o_c1_ready,
   output logic [31:0] o_c1_rdata,
   output logic        o_c1_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_valid,
   output logic [1:0]  o_owner
);

   // The state encoding doubles as the debug owner code.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t        state, state_nxt;
   logic          rr, rr_nxt;              // last client granted from IDLE
   logic [CW-1:0] outstanding, outstanding_nxt;

   logic          want0, want1;
   logic          grant_act;               // some client drives the bus this cycle
   logic          grant_sel;               // which client (0/1)
   logic          sel_ren, sel_wen, sel_hold;
   logic [31:0]   sel_addr, sel_wdata;
   logic          saturated, sel_ready;
   logic          acc_any, acc_read, valid_in_own;

   assign want0 = i_c0_ren | i_c0_wen | i_c0_hold;
   assign want1 = i_c1_ren | i_c1_wen | i_c1_hold;

   // Grant selection. In IDLE this is the combinational grant that gives the
   // first request zero added latency. A tie goes to the client that did not
   // win last time.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      grant_act = 1'b0;
      grant_sel = 1'b0;
      unique case (state)
         IDLE: begin
            if (want0 | want1) begin
               grant_act = 1'b1;
               grant_sel = (want0 & want1) ? ~rr : want1;
            end
         end
         OWN0: grant_act = 1'b1;
         OWN1: begin
            grant_act = 1'b1;
            grant_sel = 1'b1;
         end
         default: ;
      endcase
      // The bus stays quiet while reset is applied, even with the old state still held.
      if (i_rst) grant_act = 1'b0;
   end

   assign sel_ren   = grant_sel ? i_c1_ren   : i_c0_ren;
   assign sel_wen   = grant_sel ? i_c1_wen   : i_c0_wen;
   assign sel_hold  = grant_sel ? i_c1_hold  : i_c0_hold;
   assign sel_addr  = grant_sel ? i_c1_addr  : i_c0_addr;
   assign sel_wdata = grant_sel ? i_c1_wdata : i_c0_wdata;

   // A read is held back once MAX_OUT reads are in flight. Writes carry no
   // response, so they still pass.
   assign saturated = (outstanding == CW'(MAX_OUT));
   assign sel_ready = grant_act & i_mem_ready & ~(sel_ren & saturated);

   assign o_c0_ready  = sel_ready & ~grant_sel;
   assign o_c1_ready  = sel_ready &  grant_sel;

   // If ren and wen are both high, the request is a read and the write is dropped.
   assign o_mem_ren   = sel_ren & sel_ready;
   assign o_mem_wen   = sel_wen & ~sel_ren & sel_ready;
   assign o_mem_addr  = grant_act ? sel_addr  : 32'd0;
   assign o_mem_wdata = grant_act ? sel_wdata : 32'd0;

   assign acc_any  = (sel_ren | sel_wen) & sel_ready;
   assign acc_read = o_mem_ren;

   // Responses that arrive while IDLE have no owner. They are dropped and never
   // touch the counter.
   assign valid_in_own = i_mem_valid & (state != IDLE);

   assign o_c0_rdata = i_mem_rdata;
   assign o_c1_rdata = i_mem_rdata;
   assign o_c0_valid = i_mem_valid & (state == OWN0) & ~i_rst;
   assign o_c1_valid = i_mem_valid & (state == OWN1) & ~i_rst;
   assign o_owner    = state;

   always_comb begin
      state_nxt       = state;
      rr_nxt          = rr;
      outstanding_nxt = outstanding;

      // An issued read and a returned response in the same cycle cancel out.
      // A stray response with nothing outstanding is ignored.
      if (acc_read && !(valid_in_own && outstanding != '0))
         outstanding_nxt = outstanding + CW'(1);
      else if (!acc_read && valid_in_own && outstanding != '0)
         outstanding_nxt = outstanding - CW'(1);

      unique case (state)
         IDLE: begin
            if (grant_act) begin
               state_nxt = grant_sel ? OWN1 : OWN0;
               rr_nxt    = grant_sel;
            end
         end
         OWN0, OWN1: begin
            // Release only when the owner is completely quiet. Then the other
            // client can win in the IDLE cycle that follows.
            if (!sel_hold && outstanding == '0 && !acc_any && !i_mem_valid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments. Every register then
   // samples values from before the edge, whatever order the statements are in.
   // NOTE: reset is synchronous. It only takes effect on an i_clk edge, so reset
   // must be held for at least one clock.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         rr          <= 1'b1;
         outstanding <= '0;
      end else begin
         state       <= state_nxt;
         rr          <= rr_nxt;
         outstanding <= outstanding_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. An ownership model built from integers
// (owner, reads in flight, last tie winner) predicts every output on every
// cycle. Directed scenarios also pin the model with hand-computed literals. A
// memory responder returns each forwarded read after a fixed or random latency.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MAX_OUT = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_c0_ren = 1'b0, i_c0_wen = 1'b0, i_c0_hold = 1'b0;
   logic [31:0] i_c0_addr = '0, i_c0_wdata = '0;
   logic        i_c1_ren = 1'b0, i_c1_wen = 1'b0, i_c1_hold = 1'b0;
   logic [31:0] i_c1_addr = '0, i_c1_wdata = '0;
   logic        i_mem_ready = 1'b1;
   logic [31:0] i_mem_rdata = '0;
   logic        i_mem_valid = 1'b0;
   logic        o_c0_ready, o_c0_valid, o_c1_ready, o_c1_valid;
   logic [31:0] o_c0_rdata, o_c1_rdata;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic        o_mem_ren, o_mem_wen;
   logic [1:0]  o_owner;

   mem_arbiter #(.MAX_OUT(MAX_OUT), .CW(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_c0_ren(i_c0_ren), .i_c0_wen(i_c0_wen), .i_c0_addr(i_c0_addr),
      .i_c0_wdata(i_c0_wdata), .i_c0_hold(i_c0_hold), .o_c0_ready(o_c0_ready),
      .o_c0_rdata(o_c0_rdata), .o_c0_valid(o_c0_valid),
      .i_c1_ren(i_c1_ren), .i_c1_wen(i_c1_wen), .i_c1_addr(i_c1_addr),
      .i_c1_wdata(i_c1_wdata), .i_c1_hold(i_c1_hold), .o_c1_ready(o_c1_ready),
      .o_c1_rdata(o_c1_rdata), .o_c1_valid(o_c1_valid),
      .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
      .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid), .o_owner(o_owner)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(negedge i_clk);
   endtask

   // ---------------- memory responder ----------------
   // Mode 1 uses a fixed latency of 2 and mode 2 a random latency of 1..4. In
   // mode 3 the driver controls i_mem_valid/i_mem_rdata directly.
   int          mem_mode = 1;
   int          cyc = 0;
   int          rq_due[$];
   logic [31:0] rq_data[$];
   int          cnt_mem_ren = 0, cnt_c0_valid = 0, cnt_c1_valid = 0, cnt_c0_ready = 0;

   initial begin
      forever begin
         next();
         cyc++;
         if (mem_mode != 3) begin
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
               i_mem_valid = 1'b1;
               i_mem_rdata = rq_data[0];
               void'(rq_due.pop_front());
               void'(rq_data.pop_front());
            end else begin
               i_mem_valid = 1'b0;
               i_mem_rdata = $urandom;
            end
         end
         #3;
         if (o_mem_ren && mem_mode != 3) begin
            rq_due.push_back(cyc + ((mem_mode == 1) ? 2 : int'($urandom_range(1, 4))));
            rq_data.push_back(~o_mem_addr);
         end
         if (o_mem_ren)  cnt_mem_ren++;
         if (o_c0_valid) cnt_c0_valid++;
         if (o_c1_valid) cnt_c1_valid++;
         if (o_c0_ready) cnt_c0_ready++;
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   // The model tracks ownership as a client number (-1 = nobody), the number
   // of reads in flight, and the last client granted from idle.
   int m_owner = -1;
   int m_pend  = 0;
   int m_last  = 1;

   initial begin
      forever begin
         bit w0, w1, sren, swen, shold, rdy, acc;
         bit er0, er1, emr, emw, ev0, ev1;
         int g, old;
         logic [31:0] ea, ed;
         next();
         #2;
         w0 = i_c0_ren | i_c0_wen | i_c0_hold;
         w1 = i_c1_ren | i_c1_wen | i_c1_hold;
         g = -1;
         if (!i_rst) begin
            if (m_owner < 0) begin
               if (w0 && w1)  g = (m_last == 0) ? 1 : 0;
               else if (w0)   g = 0;
               else if (w1)   g = 1;
            end else begin
               g = m_owner;
            end
         end
         sren = 0; swen = 0; shold = 0; rdy = 0; ea = '0; ed = '0;
         if (g == 0) begin
            sren = i_c0_ren; swen = i_c0_wen; shold = i_c0_hold; ea = i_c0_addr; ed = i_c0_wdata;
         end else if (g == 1) begin
            sren = i_c1_ren; swen = i_c1_wen; shold = i_c1_hold; ea = i_c1_addr; ed = i_c1_wdata;
         end
         if (g >= 0) rdy = i_mem_ready && !(sren && m_pend >= MAX_OUT);
         er0 = (g == 0) && rdy;
         er1 = (g == 1) && rdy;
         emr = sren && rdy;
         emw = swen && !sren && rdy;
         ev0 = !i_rst && i_mem_valid && m_owner == 0;
         ev1 = !i_rst && i_mem_valid && m_owner == 1;

         if (checking) begin
            check("c0_ready",  32'(o_c0_ready), 32'(er0));
            check("c1_ready",  32'(o_c1_ready), 32'(er1));
            check("mem_ren",   32'(o_mem_ren),  32'(emr));
            check("mem_wen",   32'(o_mem_wen),  32'(emw));
            check("mem_addr",  o_mem_addr,      ea);
            check("mem_wdata", o_mem_wdata,     ed);
            check("c0_valid",  32'(o_c0_valid), 32'(ev0));
            check("c1_valid",  32'(o_c1_valid), 32'(ev1));
            check("c0_rdata",  o_c0_rdata,      i_mem_rdata);
            check("c1_rdata",  o_c1_rdata,      i_mem_rdata);
            check("owner",     32'(o_owner),    (m_owner < 0) ? 32'd0 : (m_owner == 0 ? 32'd1 : 32'd2));
         end

         if (i_rst) begin
            m_owner = -1; m_pend = 0; m_last = 1;
         end else if (m_owner < 0) begin
            if (g >= 0) begin
               m_owner = g;
               m_last  = g;
            end
            m_pend += int'(emr);
         end else begin
            acc = (sren || swen) && rdy;
            old = m_pend;
            m_pend += int'(emr);
            if (i_mem_valid && old > 0) m_pend--;
            if (!shold && old == 0 && !acc && !i_mem_valid) m_owner = -1;
         end
      end
   end

   // ---------------- driver helpers ----------------
   logic [31:0] last_addr, last_wdata;
   logic        last_ren, last_wen;
   int          last_wait;

   task automatic do_reset(input int mode);
      i_rst = 1'b1;
      i_c0_ren = 0; i_c0_wen = 0; i_c0_hold = 0; i_c0_addr = '0; i_c0_wdata = '0;
      i_c1_ren = 0; i_c1_wen = 0; i_c1_hold = 0; i_c1_addr = '0; i_c1_wdata = '0;
      i_mem_ready = 1'b1;
      i_mem_valid = 1'b0;
      mem_mode = mode;
      rq_due.delete();
      rq_data.delete();
      repeat (2) next();
      i_rst = 1'b0;
   endtask

   // Present one request and hold it until accepted. Returns at the next cycle
   // with ren/wen cleared.
   task automatic issue(input int c, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      int t;
      t = 0;
      if (c == 0) begin
         i_c0_ren = rd; i_c0_wen = wr; i_c0_addr = a; i_c0_wdata = d;
      end else begin
         i_c1_ren = rd; i_c1_wen = wr; i_c1_addr = a; i_c1_wdata = d;
      end
      #1;
      while (!((c == 0) ? o_c0_ready : o_c1_ready) && t < 40) begin
         next();
         #1;
         t++;
      end
      if (t >= 40) check("issue_timeout", 32'(t), 32'd0);
      last_wait  = t;
      last_addr  = o_mem_addr;
      last_wdata = o_mem_wdata;
      last_ren   = o_mem_ren;
      last_wen   = o_mem_wen;
      next();
      if (c == 0) begin i_c0_ren = 0; i_c0_wen = 0; end
      else        begin i_c1_ren = 0; i_c1_wen = 0; end
   endtask

   task automatic wait_count(input int c, input int target);
      int t;
      t = 0;
      while (((c == 0) ? cnt_c0_valid : cnt_c1_valid) < target && t < 40) begin
         next();
         t++;
      end
      if (t >= 40) check("valid_wait_timeout", 32'(t), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b_ren, b_c0v, b_c1v, b_rdy, t;
      bit starved;

      do_reset(1);
      i_rst = 1'b1;
      checking = 1'b1;
      #1;
      check("reset_owner",     32'(o_owner),   32'd0);
      check("reset_mem_ren",   32'(o_mem_ren), 32'd0);
      check("reset_c0_ready",  32'(o_c0_ready), 32'd0);
      next();
      i_rst = 1'b0;

      // --- client 0 line fill: 4 reads, hold high, latency 2 ---
      b_ren = cnt_mem_ren; b_c0v = cnt_c0_valid; b_c1v = cnt_c1_valid;
      i_c0_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(0, 1, 0, 32'h100 + 32'(4 * i), 32'h0);
         check("fill_addr", last_addr, 32'h100 + 32'(4 * i));
         if (i == 0) check("fill_first_wait", 32'(last_wait), 32'd0);
      end
      wait_count(0, b_c0v + 4);
      i_c0_hold = 1'b0;
      next();
      #1;
      check("fill_idle_after_hold", 32'(o_owner), 32'd0);
      check("fill_mem_reads",  32'(cnt_mem_ren - b_ren),  32'd4);
      check("fill_c0_valids",  32'(cnt_c0_valid - b_c0v), 32'd4);
      check("fill_c1_valids",  32'(cnt_c1_valid - b_c1v), 32'd0);

      // --- simultaneous first request after reset ---
      do_reset(1);
      i_c0_ren = 1; i_c0_addr = 32'h40;
      i_c1_ren = 1; i_c1_addr = 32'h800;
      #1;
      check("tie_addr",     o_mem_addr,        32'h40);
      check("tie_c0_ready", 32'(o_c0_ready),   32'd1);
      check("tie_c1_ready", 32'(o_c1_ready),   32'd0);
      next();
      i_c0_ren = 0;
      t = 0; starved = 1'b1;
      #1;
      while (o_owner != 2'b00 && t < 20) begin
         if (o_c1_ready) starved = 1'b0;
         next();
         #1;
         t++;
      end
      check("tie_c1_blocked",    32'(starved),    32'd1);
      check("tie_handoff_cycles", 32'(t),         32'd3);
      check("tie_c1_addr",       o_mem_addr,      32'h800);
      check("tie_c1_ren",        32'(o_mem_ren),  32'd1);
      next();
      i_c1_ren = 0;

      // --- client 1 line fill plus write-through, c0 requesting throughout ---
      do_reset(1);
      i_c1_hold = 1'b1;
      b_c1v = cnt_c1_valid;
      issue(1, 1, 0, 32'h800, 32'h0);
      i_c0_ren = 1; i_c0_addr = 32'h200;
      b_rdy = cnt_c0_ready;
      for (int i = 1; i < 4; i++) issue(1, 1, 0, 32'h800 + 32'(4 * i), 32'h0);
      issue(1, 0, 1, 32'h804, 32'hDEADBEEF);
      check("wt_wen",   32'(last_wen), 32'd1);
      check("wt_addr",  last_addr,     32'h804);
      check("wt_wdata", last_wdata,    32'hDEADBEEF);
      wait_count(1, b_c1v + 4);
      i_c1_hold = 1'b0;
      next();
      check("wt_c0_no_grant", 32'(cnt_c0_ready - b_rdy), 32'd0);
      i_c1_ren = 1; i_c1_addr = 32'h900;
      #1;
      check("wt_tie_owner",    32'(o_owner),    32'd0);
      check("wt_tie_c0_ready", 32'(o_c0_ready), 32'd1);
      check("wt_tie_c1_ready", 32'(o_c1_ready), 32'd0);
      check("wt_tie_addr",     o_mem_addr,      32'h200);
      next();
      i_c0_ren = 0; i_c1_ren = 0;

      // --- memory not ready for 5 cycles ---
      do_reset(1);
      i_mem_ready = 1'b0;
      i_c0_hold = 1'b1; i_c0_ren = 1; i_c0_addr = 32'h300;
      b_ren = cnt_mem_ren;
      repeat (5) next();
      check("stall_no_ren", 32'(cnt_mem_ren - b_ren), 32'd0);
      i_mem_ready = 1'b1;
      #1;
      check("stall_ren_on_ready", 32'(o_mem_ren), 32'd1);
      check("stall_addr",         o_mem_addr,     32'h300);
      next();
      i_c0_ren = 0; i_c0_hold = 0;

      // --- saturation: memory never answers ---
      do_reset(3);
      i_c0_hold = 1'b1; i_c0_ren = 1; i_c0_addr = 32'h400;
      b_ren = cnt_mem_ren;
      repeat (6) next();
      #1;
      check("sat_read_count", 32'(cnt_mem_ren - b_ren), 32'd4);
      check("sat_blocked",    32'(o_c0_ready),          32'd0);
      i_c0_ren = 0; i_c0_wen = 1; i_c0_wdata = 32'h1234;
      #1;
      check("sat_write_ready", 32'(o_c0_ready), 32'd1);
      check("sat_write_wen",   32'(o_mem_wen),  32'd1);
      next();
      i_c0_wen = 0; i_c0_ren = 1;
      i_mem_valid = 1; i_mem_rdata = 32'hCAFE0001;
      #1;
      check("sat_valid_still_blocked", 32'(o_c0_ready), 32'd0);
      check("sat_valid_fwd",           32'(o_c0_valid), 32'd1);
      next();
      i_mem_valid = 0;
      #1;
      check("sat_resume_ready", 32'(o_c0_ready), 32'd1);
      check("sat_resume_ren",   32'(o_mem_ren),  32'd1);
      next();
      i_c0_ren = 0; i_c0_hold = 0;

      // --- reset with two reads outstanding ---
      do_reset(3);
      i_c0_hold = 1'b1;
      issue(0, 1, 0, 32'h500, 32'h0);
      issue(0, 1, 0, 32'h504, 32'h0);
      i_rst = 1'b1;
      next();
      i_rst = 1'b0; i_c0_hold = 1'b0;
      i_mem_valid = 1; i_mem_rdata = 32'h1111;
      #1;
      check("rst_valid1_dropped", 32'(o_c0_valid), 32'd0);
      check("rst_owner",          32'(o_owner),    32'd0);
      next();
      i_mem_rdata = 32'h2222;
      i_c1_ren = 1; i_c1_addr = 32'hA00;
      #1;
      check("rst_valid2_dropped", 32'(o_c0_valid | o_c1_valid), 32'd0);
      check("rst_c1_ready",       32'(o_c1_ready),              32'd1);
      check("rst_c1_addr",        o_mem_addr,                   32'hA00);
      next();
      i_mem_valid = 0; i_c1_ren = 0;

      // --- randomized traffic, random latency and ready ---
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         i_rst       = ($urandom_range(0, 299) == 0);
         i_mem_ready = ($urandom_range(0, 9) < 8);
         i_c0_ren    = ($urandom_range(0, 9) < 4);
         i_c0_wen    = ($urandom_range(0, 9) < 2);
         i_c0_hold   = ($urandom_range(0, 9) < 3);
         i_c0_addr   = $urandom;
         i_c0_wdata  = $urandom;
         i_c1_ren    = ($urandom_range(0, 9) < 4);
         i_c1_wen    = ($urandom_range(0, 9) < 2);
         i_c1_hold   = ($urandom_range(0, 9) < 3);
         i_c1_addr   = $urandom;
         i_c1_wdata  = $urandom;
         next();
      end

      do_reset(1);
      next();
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
